rob_retire: RTL and testbench

//  Reorder buffer plus in-order commit stage; the release end of rename/dispatch.
//  - Accepts up to 2 dispatched instructions per cycle and hands back their ROB indices.
//  - Records out-of-order completions from the 3 functional units.
//  - Retires up to 2 done entries per cycle from the head.
//  - Reports each retired instruction's result for the architectural write.
//  - Returns each retired instruction's old physical register to the free pool.

---
 rtl/rob_retire_if.sv | 77 +++++++
 rtl/rob_retire.sv | 198 +++++++++++++++++++
 tb/tb_rob_retire.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_if.sv
// rtl/rob_retire_if.sv - dispatch, completion, retire and free-list signals of the reorder buffer
interface rob_retire_if #(
   parameter int IDX_W  = 4,
   parameter int AREG_W = 5,
   parameter int PREG_W = 6,
   parameter int DATA_W = 32
);
   // dispatch side
   logic              alloc_valid_1;
   logic              alloc_valid_2;
   logic [AREG_W-1:0] alloc_rd_1;
   logic [AREG_W-1:0] alloc_rd_2;
   logic [PREG_W-1:0] alloc_pd_1;
   logic [PREG_W-1:0] alloc_pd_2;
   logic [PREG_W-1:0] alloc_old_pd_1;
   logic [PREG_W-1:0] alloc_old_pd_2;
   logic [IDX_W-1:0]  alloc_idx_1;
   logic [IDX_W-1:0]  alloc_idx_2;
   logic              alloc_ready;

   // functional-unit completions
   logic              cmpl_valid_0;
   logic              cmpl_valid_1;
   logic              cmpl_valid_2;
   logic [IDX_W-1:0]  cmpl_idx_0;
   logic [IDX_W-1:0]  cmpl_idx_1;
   logic [IDX_W-1:0]  cmpl_idx_2;
   logic [DATA_W-1:0] cmpl_value_0;
   logic [DATA_W-1:0] cmpl_value_1;
   logic [DATA_W-1:0] cmpl_value_2;

   // architectural commit
   logic              ret_valid_1;
   logic              ret_valid_2;
   logic [AREG_W-1:0] ret_rd_1;
   logic [AREG_W-1:0] ret_rd_2;
   logic [PREG_W-1:0] ret_pd_1;
   logic [PREG_W-1:0] ret_pd_2;
   logic [DATA_W-1:0] ret_value_1;
   logic [DATA_W-1:0] ret_value_2;

   // free-list return
   logic              free_valid_1;
   logic              free_valid_2;
   logic [PREG_W-1:0] free_preg_1;
   logic [PREG_W-1:0] free_preg_2;

   // occupancy
   logic [IDX_W:0]    rob_count;
   logic              rob_empty;

   modport master (
      output alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
             alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2,
             cmpl_valid_0, cmpl_valid_1, cmpl_valid_2,
             cmpl_idx_0, cmpl_idx_1, cmpl_idx_2,
             cmpl_value_0, cmpl_value_1, cmpl_value_2,
      input  alloc_idx_1, alloc_idx_2, alloc_ready,
             ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2,
             ret_pd_1, ret_pd_2, ret_value_1, ret_value_2,
             free_valid_1, free_valid_2, free_preg_1, free_preg_2,
             rob_count, rob_empty
   );

   modport slave (
      input  alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
             alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2,
             cmpl_valid_0, cmpl_valid_1, cmpl_valid_2,
             cmpl_idx_0, cmpl_idx_1, cmpl_idx_2,
             cmpl_value_0, cmpl_value_1, cmpl_value_2,
      output alloc_idx_1, alloc_idx_2, alloc_ready,
             ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2,
             ret_pd_1, ret_pd_2, ret_value_1, ret_value_2,
             free_valid_1, free_valid_2, free_preg_1, free_preg_2,
             rob_count, rob_empty
   );
endinterface

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - reorder buffer with 2-wide dispatch, 3 completion ports and 2-wide in-order retire
module rob_retire #(
   parameter int ROB_DEPTH = 16,
   parameter int IDX_W     = 4,
   parameter int AREG_W    = 5,
   parameter int PREG_W    = 6,
   parameter int DATA_W    = 32
) (
   input  logic       clk,
   input  logic       reset,
   rob_retire_if.slave bus
);
   localparam int                CNT_W       = IDX_W + 1;
   localparam int                N_FU        = 3;
   localparam logic [CNT_W-1:0]  ALLOC_LIMIT = CNT_W'(ROB_DEPTH - 2);

   // entry control bits (reset) and payload (no reset, only meaningful while valid)
   logic [ROB_DEPTH-1:0] valid_q;
   logic [ROB_DEPTH-1:0] done_q;
   logic [AREG_W-1:0]    rd_q     [ROB_DEPTH];
   logic [PREG_W-1:0]    pd_q     [ROB_DEPTH];
   logic [PREG_W-1:0]    old_pd_q [ROB_DEPTH];
   logic [DATA_W-1:0]    value_q  [ROB_DEPTH];

   logic [IDX_W-1:0]     head_q;
   logic [IDX_W-1:0]     tail_q;
   logic [IDX_W-1:0]     head_p1;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_next;

   // completion ports flattened into arrays so the port priority is a loop order
   logic                 cmpl_valid [N_FU];
   logic [IDX_W-1:0]     cmpl_idx   [N_FU];
   logic [DATA_W-1:0]    cmpl_value [N_FU];
   logic                 cmpl_hit   [N_FU];

   logic                 alloc_ready;
   logic                 acc_1;
   logic                 acc_2;
   logic [IDX_W-1:0]     alloc_idx_1;
   logic [IDX_W-1:0]     alloc_idx_2;
   logic [1:0]           n_alloc;

   logic                 ret_1;
   logic                 ret_2;
   logic                 free_1;
   logic                 free_2;
   logic [1:0]           n_ret;

   // registered retire / free pulses
   logic                 ret_valid_1_q;
   logic                 ret_valid_2_q;
   logic [AREG_W-1:0]    ret_rd_1_q;
   logic [AREG_W-1:0]    ret_rd_2_q;
   logic [PREG_W-1:0]    ret_pd_1_q;
   logic [PREG_W-1:0]    ret_pd_2_q;
   logic [DATA_W-1:0]    ret_value_1_q;
   logic [DATA_W-1:0]    ret_value_2_q;
   logic                 free_valid_1_q;
   logic                 free_valid_2_q;
   logic [PREG_W-1:0]    free_preg_1_q;
   logic [PREG_W-1:0]    free_preg_2_q;

   assign cmpl_valid[0] = bus.cmpl_valid_0;
   assign cmpl_valid[1] = bus.cmpl_valid_1;
   assign cmpl_valid[2] = bus.cmpl_valid_2;
   assign cmpl_idx[0]   = bus.cmpl_idx_0;
   assign cmpl_idx[1]   = bus.cmpl_idx_1;
   assign cmpl_idx[2]   = bus.cmpl_idx_2;
   assign cmpl_value[0] = bus.cmpl_value_0;
   assign cmpl_value[1] = bus.cmpl_value_1;
   assign cmpl_value[2] = bus.cmpl_value_2;

   // Dispatch acceptance depends only on the registered count, so a slot that is
   // retiring this cycle is never handed out again in the same cycle.
   assign alloc_ready = (count_q <= ALLOC_LIMIT);
   assign acc_1       = alloc_ready && bus.alloc_valid_1;
   assign acc_2       = alloc_ready && bus.alloc_valid_2;
   assign alloc_idx_1 = tail_q;
   assign alloc_idx_2 = tail_q + IDX_W'(bus.alloc_valid_1);
   assign n_alloc     = {1'b0, acc_1} + {1'b0, acc_2};

   // Retire picks from the pre-edge head; slot 2 only ever follows slot 1.
   assign head_p1     = head_q + IDX_W'(1);
   assign ret_1       = valid_q[head_q] && done_q[head_q];
   assign ret_2       = ret_1 && valid_q[head_p1] && done_q[head_p1];
   assign free_1      = ret_1 && (rd_q[head_q] != '0);
   assign free_2      = ret_2 && (rd_q[head_p1] != '0);
   assign n_ret       = {1'b0, ret_1} + {1'b0, ret_2};

   assign count_next  = count_q + CNT_W'(n_alloc) - CNT_W'(n_ret);

   // A completion only counts against an entry that was live before the edge.
   always_comb begin
      for (int k = 0; k < N_FU; k++) begin
         cmpl_hit[k] = cmpl_valid[k] && valid_q[cmpl_idx[k]];
      end
   end

   // Entry valid/done flags, pointers, occupancy and retire pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q        <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         ret_valid_1_q  <= 1'b0;
         ret_valid_2_q  <= 1'b0;
         ret_rd_1_q     <= '0;
         ret_rd_2_q     <= '0;
         ret_pd_1_q     <= '0;
         ret_pd_2_q     <= '0;
         ret_value_1_q  <= '0;
         ret_value_2_q  <= '0;
         free_valid_1_q <= 1'b0;
         free_valid_2_q <= 1'b0;
         free_preg_1_q  <= '0;
         free_preg_2_q  <= '0;
      end else begin
         for (int k = 0; k < N_FU; k++) begin
            if (cmpl_hit[k]) begin
               done_q[cmpl_idx[k]] <= 1'b1;
            end
         end
         if (ret_1) begin
            valid_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
         end
         if (ret_2) begin
            valid_q[head_p1] <= 1'b0;
            done_q[head_p1]  <= 1'b0;
         end
         if (acc_1) begin
            valid_q[alloc_idx_1] <= 1'b1;
            done_q[alloc_idx_1]  <= 1'b0;
         end
         if (acc_2) begin
            valid_q[alloc_idx_2] <= 1'b1;
            done_q[alloc_idx_2]  <= 1'b0;
         end

         head_q  <= head_q + IDX_W'(n_ret);
         tail_q  <= tail_q + IDX_W'(n_alloc);
         count_q <= count_next;

         ret_valid_1_q  <= ret_1;
         ret_valid_2_q  <= ret_2;
         ret_rd_1_q     <= ret_1 ? rd_q[head_q]     : '0;
         ret_rd_2_q     <= ret_2 ? rd_q[head_p1]    : '0;
         ret_pd_1_q     <= ret_1 ? pd_q[head_q]     : '0;
         ret_pd_2_q     <= ret_2 ? pd_q[head_p1]    : '0;
         ret_value_1_q  <= ret_1 ? value_q[head_q]  : '0;
         ret_value_2_q  <= ret_2 ? value_q[head_p1] : '0;
         free_valid_1_q <= free_1;
         free_valid_2_q <= free_2;
         free_preg_1_q  <= free_1 ? old_pd_q[head_q]  : '0;
         free_preg_2_q  <= free_2 ? old_pd_q[head_p1] : '0;
      end
   end

   // Entry payload: later completion ports win on a shared index; dispatch fills fresh slots.
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_FU; k++) begin
         if (cmpl_hit[k]) begin
            value_q[cmpl_idx[k]] <= cmpl_value[k];
         end
      end
      if (acc_1) begin
         rd_q[alloc_idx_1]     <= bus.alloc_rd_1;
         pd_q[alloc_idx_1]     <= bus.alloc_pd_1;
         old_pd_q[alloc_idx_1] <= bus.alloc_old_pd_1;
      end
      if (acc_2) begin
         rd_q[alloc_idx_2]     <= bus.alloc_rd_2;
         pd_q[alloc_idx_2]     <= bus.alloc_pd_2;
         old_pd_q[alloc_idx_2] <= bus.alloc_old_pd_2;
      end
   end

   assign bus.alloc_idx_1  = alloc_idx_1;
   assign bus.alloc_idx_2  = alloc_idx_2;
   assign bus.alloc_ready  = alloc_ready;
   assign bus.ret_valid_1  = ret_valid_1_q;
   assign bus.ret_valid_2  = ret_valid_2_q;
   assign bus.ret_rd_1     = ret_rd_1_q;
   assign bus.ret_rd_2     = ret_rd_2_q;
   assign bus.ret_pd_1     = ret_pd_1_q;
   assign bus.ret_pd_2     = ret_pd_2_q;
   assign bus.ret_value_1  = ret_value_1_q;
   assign bus.ret_value_2  = ret_value_2_q;
   assign bus.free_valid_1 = free_valid_1_q;
   assign bus.free_valid_2 = free_valid_2_q;
   assign bus.free_preg_1  = free_preg_1_q;
   assign bus.free_preg_2  = free_preg_2_q;
   assign bus.rob_count    = count_q;
   assign bus.rob_empty    = (count_q == '0);
endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - randomized and directed bench for rob_retire against a queue model
module tb_rob_retire;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rob_retire_if bus ();
   rob_retire dut (.clk(clk), .reset(reset), .bus(bus));

   logic        av1, av2;
   logic [4:0]  rd1, rd2;
   logic [5:0]  pd1, pd2, op1, op2;
   logic        cv   [3];
   logic [3:0]  ci   [3];
   logic [31:0] cval [3];

   assign bus.alloc_valid_1  = av1;
   assign bus.alloc_valid_2  = av2;
   assign bus.alloc_rd_1     = rd1;
   assign bus.alloc_rd_2     = rd2;
   assign bus.alloc_pd_1     = pd1;
   assign bus.alloc_pd_2     = pd2;
   assign bus.alloc_old_pd_1 = op1;
   assign bus.alloc_old_pd_2 = op2;
   assign bus.cmpl_valid_0   = cv[0];
   assign bus.cmpl_valid_1   = cv[1];
   assign bus.cmpl_valid_2   = cv[2];
   assign bus.cmpl_idx_0     = ci[0];
   assign bus.cmpl_idx_1     = ci[1];
   assign bus.cmpl_idx_2     = ci[2];
   assign bus.cmpl_value_0   = cval[0];
   assign bus.cmpl_value_1   = cval[1];
   assign bus.cmpl_value_2   = cval[2];

   // reference model: program-order queue of in-flight instructions
   typedef struct packed {
      logic [4:0]  rd;
      logic [5:0]  pd;
      logic [5:0]  old;
      logic [31:0] val;
      logic        done;
   } ent_t;
   ent_t mq[$];
   int   m_head;

   // expected retire slot: {ret_valid, rd, pd, value, free_valid, free_preg}
   logic [50:0] e_s1, e_s2;

   int n_pass  = 0;
   int n_total = 0;

   task automatic clear_inputs();
      av1 = 0; av2 = 0; rd1 = 0; rd2 = 0; pd1 = 0; pd2 = 0; op1 = 0; op2 = 0;
      for (int k = 0; k < 3; k++) begin
         cv[k] = 0; ci[k] = 0; cval[k] = 0;
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_head = 0;
      e_s1 = '0;
      e_s2 = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [50:0] slot_of(input ent_t e, input logic fire);
      logic fr;
      fr = fire && (e.rd != 0);
      if (!fire) return '0;
      return {1'b1, e.rd, e.pd, e.val, fr, fr ? e.old : 6'd0};
   endfunction

   // advance the model by one clock using the currently driven inputs, then clock the DUT
   task automatic step();
      int   sz, off;
      logic rdy, r1, r2;
      ent_t e;
      sz  = mq.size();
      rdy = (sz <= 14);
      r1  = (sz >= 1) && mq[0].done;
      r2  = r1 && (sz >= 2) && mq[1].done;
      e_s1 = r1 ? slot_of(mq[0], 1'b1) : '0;
      e_s2 = r2 ? slot_of(mq[1], 1'b1) : '0;
      for (int k = 0; k < 3; k++) begin
         if (cv[k]) begin
            off = (int'(ci[k]) - m_head + 16) % 16;
            if (off < sz) begin
               e = mq[off]; e.done = 1'b1; e.val = cval[k]; mq[off] = e;
            end
         end
      end
      if (r1) begin void'(mq.pop_front()); m_head = (m_head + 1) % 16; end
      if (r2) begin void'(mq.pop_front()); m_head = (m_head + 1) % 16; end
      if (rdy && av1) begin e = '{rd1, pd1, op1, 32'd0, 1'b0}; mq.push_back(e); end
      if (rdy && av2) begin e = '{rd2, pd2, op2, 32'd0, 1'b0}; mq.push_back(e); end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] m_tail();
      return 4'((m_head + mq.size()) % 16);
   endfunction

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({bus.rob_count, bus.rob_empty, bus.alloc_ready} !== {5'd0, 1'b1, 1'b1})
         $display("FAIL reset_status got %h want %h", {bus.rob_count, bus.rob_empty, bus.alloc_ready}, {5'd0, 1'b1, 1'b1});
      else n_pass++;
      n_total++;
      if ({bus.ret_valid_1, bus.ret_valid_2, bus.free_valid_1, bus.free_valid_2} !== 4'b0)
         $display("FAIL reset_pulses got %b want 0000", {bus.ret_valid_1, bus.ret_valid_2, bus.free_valid_1, bus.free_valid_2});
      else n_pass++;
   endtask

   task automatic test_retire_pair();
      clear_inputs();
      av1 = 1; rd1 = 3; pd1 = 33; op1 = 3;
      av2 = 1; rd2 = 4; pd2 = 34; op2 = 4;
      #1;
      n_total++;
      if ({bus.alloc_idx_1, bus.alloc_idx_2} !== {4'd0, 4'd1})
         $display("FAIL pair_idx got %h want 01", {bus.alloc_idx_1, bus.alloc_idx_2});
      else n_pass++;
      step();
      clear_inputs(); cv[1] = 1; ci[1] = 1; cval[1] = 32'h55;
      step();
      clear_inputs(); cv[0] = 1; ci[0] = 0; cval[0] = 32'hAA;
      step();
      clear_inputs();
      n_total++;
      if (bus.ret_valid_1 !== 1'b0)
         $display("FAIL pair_early got %b want 0", bus.ret_valid_1);
      else n_pass++;
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.ret_rd_1, bus.ret_pd_1, bus.ret_value_1, bus.free_valid_1, bus.free_preg_1}
          !== {1'b1, 5'd3, 6'd33, 32'hAA, 1'b1, 6'd3})
         $display("FAIL pair_slot1 got rd=%0d val=%h fp=%0d want rd=3 val=aa fp=3", bus.ret_rd_1, bus.ret_value_1, bus.free_preg_1);
      else n_pass++;
      n_total++;
      if ({bus.ret_valid_2, bus.ret_rd_2, bus.ret_pd_2, bus.ret_value_2, bus.free_valid_2, bus.free_preg_2}
          !== {1'b1, 5'd4, 6'd34, 32'h55, 1'b1, 6'd4})
         $display("FAIL pair_slot2 got rd=%0d val=%h fp=%0d want rd=4 val=55 fp=4", bus.ret_rd_2, bus.ret_value_2, bus.free_preg_2);
      else n_pass++;
      n_total++;
      if (bus.rob_count !== 5'd0)
         $display("FAIL pair_count got %0d want 0", bus.rob_count);
      else n_pass++;
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.ret_valid_2} !== 2'b00)
         $display("FAIL pair_pulse got %b want 00", {bus.ret_valid_1, bus.ret_valid_2});
      else n_pass++;
   endtask

   task automatic test_hold_order();
      logic [3:0] t;
      t = m_tail();
      clear_inputs();
      av1 = 1; rd1 = 5; pd1 = 40; op1 = 5;
      av2 = 1; rd2 = 6; pd2 = 41; op2 = 6;
      step();
      clear_inputs(); cv[2] = 1; ci[2] = t + 4'd1; cval[2] = 32'h66;
      step();
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++;
         if ({bus.ret_valid_1, bus.ret_valid_2, bus.rob_count} !== {2'b00, 5'd2})
            $display("FAIL hold_no_retire cyc %0d got %h want 02", i, {bus.ret_valid_1, bus.ret_valid_2, bus.rob_count});
         else n_pass++;
      end
      cv[0] = 1; ci[0] = t; cval[0] = 32'h11;
      step();
      clear_inputs();
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.ret_rd_1, bus.ret_value_1, bus.ret_valid_2, bus.ret_rd_2, bus.ret_value_2}
          !== {1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h66})
         $display("FAIL hold_release got %0d/%h %0d/%h want 5/11 6/66", bus.ret_rd_1, bus.ret_value_1, bus.ret_rd_2, bus.ret_value_2);
      else n_pass++;
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         av1 = 1; rd1 = 5'(2 * i + 1); pd1 = 6'(32 + 2 * i); op1 = 6'(2 * i + 1);
         av2 = 1; rd2 = 5'(2 * i + 2); pd2 = 6'(33 + 2 * i); op2 = 6'(2 * i + 2);
         step();
      end
      clear_inputs();
      n_total++;
      if ({bus.rob_count, bus.rob_empty, bus.alloc_ready} !== {5'd16, 1'b0, 1'b0})
         $display("FAIL full_status got %h want %h", {bus.rob_count, bus.rob_empty, bus.alloc_ready}, {5'd16, 1'b0, 1'b0});
      else n_pass++;
      av1 = 1; rd1 = 9; av2 = 1; rd2 = 9;
      step();
      clear_inputs();
      n_total++;
      if (bus.rob_count !== 5'd16)
         $display("FAIL full_ignore got %0d want 16", bus.rob_count);
      else n_pass++;
      cv[0] = 1; ci[0] = 0; cval[0] = 32'hA0;
      cv[2] = 1; ci[2] = 1; cval[2] = 32'hA1;
      step();
      clear_inputs();
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.ret_rd_1, bus.ret_valid_2, bus.ret_rd_2, bus.rob_count, bus.alloc_ready}
          !== {1'b1, 5'd1, 1'b1, 5'd2, 5'd14, 1'b1})
         $display("FAIL full_drain got %h want %h", {bus.ret_valid_1, bus.ret_rd_1, bus.ret_valid_2, bus.ret_rd_2, bus.rob_count, bus.alloc_ready},
                  {1'b1, 5'd1, 1'b1, 5'd2, 5'd14, 1'b1});
      else n_pass++;
      av1 = 1; rd1 = 20; pd1 = 50; op1 = 20;
      av2 = 1; rd2 = 21; pd2 = 51; op2 = 21;
      #1;
      n_total++;
      if ({bus.alloc_idx_1, bus.alloc_idx_2} !== {4'd0, 4'd1})
         $display("FAIL wrap_idx got %h want 01", {bus.alloc_idx_1, bus.alloc_idx_2});
      else n_pass++;
      step();
      clear_inputs();
      n_total++;
      if (bus.rob_count !== 5'd16)
         $display("FAIL wrap_count got %0d want 16", bus.rob_count);
      else n_pass++;
   endtask

   task automatic test_x0();
      do_reset();
      av1 = 1; rd1 = 0; pd1 = 0; op1 = 9;
      step();
      clear_inputs(); cv[1] = 1; ci[1] = 0; cval[1] = 32'h77;
      step();
      clear_inputs();
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.ret_rd_1, bus.ret_value_1} !== {1'b1, 5'd0, 32'h77})
         $display("FAIL x0_retire got %h want %h", {bus.ret_valid_1, bus.ret_rd_1, bus.ret_value_1}, {1'b1, 5'd0, 32'h77});
      else n_pass++;
      n_total++;
      if ({bus.free_valid_1, bus.free_valid_2, bus.ret_valid_2} !== 3'b000)
         $display("FAIL x0_free got %b want 000", {bus.free_valid_1, bus.free_valid_2, bus.ret_valid_2});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         av1 = 1; rd1 = 5'(7 + 2 * i); pd1 = 6'(10 + i); op1 = 6'(20 + i);
         av2 = (i < 2); rd2 = 5'(8 + 2 * i); pd2 = 6'(13 + i); op2 = 6'(23 + i);
         step();
      end
      clear_inputs();
      cv[0] = 1; ci[0] = 0; cval[0] = 32'hC0;
      cv[1] = 1; ci[1] = 3; cval[1] = 32'hC3;
      step();
      clear_inputs();
      step();
      n_total++;
      if ({bus.ret_valid_1, bus.free_valid_1, bus.rob_count} !== {1'b1, 1'b1, 5'd4})
         $display("FAIL mid_before got %h want %h", {bus.ret_valid_1, bus.free_valid_1, bus.rob_count}, {1'b1, 1'b1, 5'd4});
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_total++;
      if ({bus.ret_valid_1, bus.free_valid_1, bus.ret_valid_2, bus.free_valid_2, bus.free_preg_1} !== 10'b0)
         $display("FAIL mid_pulses got %h want 0", {bus.ret_valid_1, bus.free_valid_1, bus.ret_valid_2, bus.free_valid_2, bus.free_preg_1});
      else n_pass++;
      n_total++;
      if ({bus.rob_count, bus.rob_empty, bus.alloc_ready} !== {5'd0, 1'b1, 1'b1})
         $display("FAIL mid_status got %h want %h", {bus.rob_count, bus.rob_empty, bus.alloc_ready}, {5'd0, 1'b1, 1'b1});
      else n_pass++;
      #1;
      reset = 1'b0;
      model_clear();
      cv[0] = 1; ci[0] = 1; cval[0] = 32'hD1;
      cv[2] = 1; ci[2] = 2; cval[2] = 32'hD2;
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         step();
         n_total++;
         if ({bus.ret_valid_1, bus.ret_valid_2, bus.rob_count} !== {2'b00, 5'd0})
            $display("FAIL mid_stale cyc %0d got %h want 0", i, {bus.ret_valid_1, bus.ret_valid_2, bus.rob_count});
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int          sz;
      logic [3:0]  t;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         clear_inputs();
         sz  = mq.size();
         av1 = ($urandom_range(0, 99) < 55);
         av2 = ($urandom_range(0, 99) < 45);
         rd1 = 5'($urandom_range(0, 31)); pd1 = 6'($urandom_range(0, 63)); op1 = 6'($urandom_range(0, 63));
         rd2 = 5'($urandom_range(0, 31)); pd2 = 6'($urandom_range(0, 63)); op2 = 6'($urandom_range(0, 63));
         for (int k = 0; k < 3; k++) begin
            cv[k]   = ($urandom_range(0, 99) < 50);
            cval[k] = $urandom;
            if (sz > 0 && $urandom_range(0, 9) != 0)
               ci[k] = 4'((m_head + $urandom_range(0, sz - 1)) % 16);
            else
               ci[k] = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 9) == 0) begin
            cv[0] = 1; cv[2] = 1; ci[2] = ci[0];
         end
         #1;
         t = m_tail();
         n_total++;
         if ({bus.alloc_idx_1, bus.alloc_idx_2, bus.alloc_ready} !== {t, 4'(t + 4'(av1)), (sz <= 14)})
            $display("FAIL rnd_alloc cyc %0d got %h want %h", c, {bus.alloc_idx_1, bus.alloc_idx_2, bus.alloc_ready},
                     {t, 4'(t + 4'(av1)), (sz <= 14)});
         else n_pass++;
         step();
         sz = mq.size();
         n_total++;
         if ({bus.ret_valid_1, bus.ret_rd_1, bus.ret_pd_1, bus.ret_value_1, bus.free_valid_1, bus.free_preg_1} !== e_s1)
            $display("FAIL rnd_slot1 cyc %0d got %h want %h", c,
                     {bus.ret_valid_1, bus.ret_rd_1, bus.ret_pd_1, bus.ret_value_1, bus.free_valid_1, bus.free_preg_1}, e_s1);
         else n_pass++;
         n_total++;
         if ({bus.ret_valid_2, bus.ret_rd_2, bus.ret_pd_2, bus.ret_value_2, bus.free_valid_2, bus.free_preg_2} !== e_s2)
            $display("FAIL rnd_slot2 cyc %0d got %h want %h", c,
                     {bus.ret_valid_2, bus.ret_rd_2, bus.ret_pd_2, bus.ret_value_2, bus.free_valid_2, bus.free_preg_2}, e_s2);
         else n_pass++;
         n_total++;
         if ({bus.rob_count, bus.rob_empty} !== {5'(sz), (sz == 0)})
            $display("FAIL rnd_count cyc %0d got %0d want %0d", c, bus.rob_count, sz);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_clear();
      test_reset();
      test_retire_pair();
      test_hold_order();
      test_full_wrap();
      test_x0();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
